// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide unit for the multicycle MIPS core: one bit per cycle,
// shift-add multiply and restoring divide on operand magnitudes, sign fix-up at the end.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic             busy,
  output logic             done,
  output logic             hl_we,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             div0
);

  localparam int W2    = 2 * WIDTH;
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_RUN, S_FIX, S_DONE} state_t;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
    logic signed [WIDTH-1:0] sv;
    sv = $signed(v);
    return (sgn && (sv < 0)) ? -v : v;
  endfunction

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  function automatic logic [W2-1:0] neg_2w(input logic [W2-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q, done_q, div0_q;
  logic [WIDTH-1:0] hi_q, lo_q;

  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q, dv_q;
  logic [W2:0]      acc_q;
  logic             negq_q, negr_q;

  logic             is_div, is_sgn, dz;
  logic [WIDTH:0]   mul_hi, trial;
  logic [W2:0]      div_sh, acc_d;
  logic [W2-1:0]    prod_fix;
  logic [WIDTH-1:0] quot_fix, rem_fix;

  assign is_div = op_q[1];
  assign is_sgn = ~op_q[0];
  assign dz     = is_div && (b_q == '0);

  // One iteration: acc holds {partial product, multiplier} or {remainder, quotient}.
  always_comb begin
    mul_hi = acc_q[W2:WIDTH] + {1'b0, dv_q};
    div_sh = {acc_q[W2-1:0], 1'b0};
    trial  = div_sh[W2:WIDTH] - {1'b0, dv_q};
    acc_d  = div_sh;
    if (is_div) begin
      if (!trial[WIDTH]) acc_d = {trial, div_sh[WIDTH-1:1], 1'b1};
    end else if (acc_q[0]) begin
      acc_d = {1'b0, mul_hi, acc_q[WIDTH-1:1]};
    end else begin
      acc_d = {1'b0, acc_q[W2:1]};
    end
  end

  assign prod_fix = neg_2w(acc_q[W2-1:0], negq_q);
  assign quot_fix = neg_w(acc_q[WIDTH-1:0], negq_q);
  assign rem_fix  = neg_w(acc_q[W2-1:WIDTH], negr_q);

  // Datapath registers carry no reset; they are always loaded before use.
  always_ff @(posedge CLK) begin
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_q <= op;
          a_q  <= rs_val;
          b_q  <= rt_val;
        end
      end
      S_PREP: begin
        negq_q <= is_sgn & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
        negr_q <= is_sgn & a_q[WIDTH-1];
        dv_q   <= is_div ? mag(b_q, is_sgn) : mag(a_q, is_sgn);
        acc_q  <= {{(WIDTH+1){1'b0}}, (is_div ? mag(a_q, is_sgn) : mag(b_q, is_sgn))};
      end
      S_RUN:   acc_q <= acc_d;
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      div0_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q <= S_PREP;
            busy_q  <= 1'b1;
          end
        end
        S_PREP: begin
          cnt_q <= '0;
          if (dz) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            div0_q  <= 1'b1;
            hi_q    <= a_q;
            lo_q    <= '1;
          end else begin
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) state_q <= S_FIX;
        end
        S_FIX: begin
          state_q <= S_DONE;
          cnt_q   <= '0;
          done_q  <= 1'b1;
          div0_q  <= 1'b0;
          hi_q    <= is_div ? rem_fix  : prod_fix[W2-1:WIDTH];
          lo_q    <= is_div ? quot_fix : prod_fix[WIDTH-1:0];
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign hl_we  = done_q;
  assign div0   = div0_q;
  assign hi_out = hi_q;
  assign lo_out = lo_q;

endmodule
